// File: rtl/pmem_arb_pkg.sv
// Shared types for the I/D physical-memory arbiter.
// Holds FSM states, requester ids and width defaults.
package pmem_arb_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    GAP
  } state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } op_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical memory port
// between the instruction and data caches.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_t            state;
  state_t            state_nx;
  req_id_t           last;
  req_id_t           last_nx;
  op_t               op_q;
  op_t               op_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] wdata_nx;

  logic pend_i;
  logic pend_d;
  logic win_i;
  logic win_d;
  logic grant;

  // D wins a tie unless it was the one served last
  always_comb begin
    pend_i = i_read;
    pend_d = d_read | d_write;
    win_d  = pend_d & (~pend_i | (last == REQ_I));
    win_i  = pend_i & ~win_d;
  end

  always_comb begin
    op_nx    = op_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    unique case (1'b1)
      win_d: begin
        op_nx.wr = d_write;
        op_nx.rd = ~d_write;
        addr_nx  = d_address;
        wdata_nx = d_wdata;
      end
      win_i: begin
        op_nx.wr = 1'b0;
        op_nx.rd = 1'b1;
        addr_nx  = i_address;
      end
      default: begin
        op_nx = op_q;
      end
    endcase
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    grant      = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_d) begin
          state_nx = SERVE_D;
          last_nx  = REQ_D;
          grant    = 1'b1;
        end else if (win_i) begin
          state_nx = SERVE_I;
          last_nx  = REQ_I;
          grant    = 1'b1;
        end
      end
      SERVE_I: begin
        pmem_read  = op_q.rd;
        pmem_write = op_q.wr;
        if (pmem_resp) begin
          i_resp   = 1'b1;
          state_nx = GAP;
        end
      end
      SERVE_D: begin
        pmem_read  = op_q.rd;
        pmem_write = op_q.wr;
        if (pmem_resp) begin
          d_resp   = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= REQ_I;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  // Command copies only move on a grant, so requesters may
  // change their inputs freely once they are being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      op_q    <= op_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule
